// File: rtl/ssp_audio_conditioner.sv
// ssp_audio_conditioner: decimate the PSG sum, remove DC, emit signed 16-bit PCM over valid/ready
module ssp_audio_conditioner #(
  parameter int SAMPLE_DIV = 1125,
  parameter int DC_SHIFT = 10
) (
  input  logic        clk_logic_i,
  input  logic        reset_i,
  input  logic        enable_i,
  input  logic [9:0]  audio_i,
  output logic [15:0] sample_o,
  output logic        sample_valid_o,
  input  logic        sample_ready_i,
  output logic        overrun_o
);
  localparam int W = 10 + DC_SHIFT;
  localparam logic [23:0] RECIP = 24'((2 ** 25 / SAMPLE_DIV + 1) / 2);
  logic [11:0] phase_q, phase_d;
  logic [21:0] acc_q, acc_d, sum, s1_q;
  logic s1_v_q, s2_v_q, last;
  logic [9:0] s2_q, mean, dc;
  logic [47:0] scaled;
  logic [W-1:0] dc_acc_q, dc_acc_d;
  logic [10:0] y;
  logic [15:0] sample_d;
  logic valid_d, ovr_d;
  // window accumulation: the terminal cycle's input joins the closing window
  always_comb begin
    last = phase_q == 12'(SAMPLE_DIV - 1);
    sum = acc_q + 22'(audio_i);
    phase_d = last ? 12'd0 : phase_q + 12'd1;
    acc_d = last ? 22'd0 : sum;
  end
  // mean by reciprocal multiply, DC tracking, and output handshake next-state
  always_comb begin
    scaled = 48'(s1_q) * 48'(RECIP) + 48'h80_0000;
    mean = |scaled[47:34] ? 10'h3ff : scaled[33:24];
    dc = 10'(dc_acc_q >> DC_SHIFT);
    y = {1'b0, s2_q} - {1'b0, dc};
    dc_acc_d = s2_v_q ? (enable_i ? dc_acc_q + W'(s2_q) - W'(dc) : '0) : dc_acc_q;
    sample_d = s2_v_q ? (enable_i ? {y, 5'd0} : 16'd0) : sample_o;
    valid_d = s2_v_q | (sample_valid_o & ~sample_ready_i);
    ovr_d = overrun_o | (s2_v_q & sample_valid_o & ~sample_ready_i);
  end
  // all state: free-running window, three-stage pipeline, output register
  always_ff @(posedge clk_logic_i) begin
    if (reset_i) begin
      phase_q <= '0;
      acc_q <= '0;
      s1_q <= '0;
      s1_v_q <= 1'b0;
      s2_q <= '0;
      s2_v_q <= 1'b0;
      dc_acc_q <= '0;
      sample_o <= '0;
      sample_valid_o <= 1'b0;
      overrun_o <= 1'b0;
    end else begin
      phase_q <= phase_d;
      acc_q <= acc_d;
      s1_v_q <= last;
      if (last) s1_q <= sum;
      s2_v_q <= s1_v_q;
      if (s1_v_q) s2_q <= mean;
      dc_acc_q <= dc_acc_d;
      sample_o <= sample_d;
      sample_valid_o <= valid_d;
      overrun_o <= ovr_d;
    end
  end
endmodule

// File: tb/tb_ssp_audio_conditioner.sv
// tb_ssp_audio_conditioner: directed and random checks against a per-window arithmetic model
module tb_ssp_audio_conditioner;
  localparam int D = 4;
  localparam int S = 2;
  localparam longint RECIP_M = ((64'd1 << 24) + D / 2) / D;
  logic clk = 1'b0;
  logic rst = 1'b1, en = 1'b1, rdy = 1'b1;
  logic [9:0] audio = '0;
  logic [15:0] sample;
  logic valid, ovr;
  logic rst_b = 1'b1, en_b = 1'b1, rdy_b = 1'b1;
  logic [9:0] audio_b = 10'd1023;
  logic [15:0] sample_b;
  logic valid_b, ovr_b;
  int total = 0, bad = 0;
  int cyc = 0;
  int m_phase = 0, m_sum = 0, m_dc = 0;
  logic [15:0] m_out = '0;
  logic m_valid = 1'b0, m_ovr = 1'b0;
  typedef struct {int due; int mean;} pend_t;
  pend_t pq[$];

  always #5 clk = ~clk;

  ssp_audio_conditioner #(.SAMPLE_DIV(D), .DC_SHIFT(S)) dut (
    .clk_logic_i(clk), .reset_i(rst), .enable_i(en), .audio_i(audio),
    .sample_o(sample), .sample_valid_o(valid), .sample_ready_i(rdy), .overrun_o(ovr)
  );

  ssp_audio_conditioner dut_b (
    .clk_logic_i(clk), .reset_i(rst_b), .enable_i(en_b), .audio_i(audio_b),
    .sample_o(sample_b), .sample_valid_o(valid_b), .sample_ready_i(rdy_b), .overrun_o(ovr_b)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    assert (got === want) else begin
      bad++;
      $error("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  // one clock: update the model from the inputs about to be sampled, then compare
  task automatic step();
    int nc, mean, dcq, y;
    longint mm;
    nc = 0;
    if (rst) begin
      m_phase = 0; m_sum = 0; m_dc = 0; m_out = '0; m_valid = 0; m_ovr = 0;
      pq.delete();
    end else begin
      if (pq.size() > 0 && pq[0].due == cyc) begin
        mean = pq[0].mean;
        void'(pq.pop_front());
        if (en) begin
          dcq = m_dc >> S;
          y = mean - dcq;
          m_dc += y;
          m_out = 16'(y * 32);
        end else begin
          m_dc = 0;
          m_out = '0;
        end
        if (m_valid && !rdy) m_ovr = 1'b1;
        m_valid = 1'b1;
      end else if (m_valid && rdy) m_valid = 1'b0;
      m_sum += int'(audio);
      if (m_phase == D - 1) begin
        mm = (longint'(m_sum) * RECIP_M + (longint'(1) << 23)) >>> 24;
        if (mm > 1023) mm = 1023;
        pq.push_back('{due: cyc + 2, mean: int'(mm)});
        m_sum = 0;
        m_phase = 0;
      end else m_phase++;
      nc = cyc + 1;
    end
    @(posedge clk);
    #1;
    cyc = nc;
    chk("model_sample", {16'd0, sample}, {16'd0, m_out});
    chk("model_valid", {31'd0, valid}, {31'd0, m_valid});
    chk("model_overrun", {31'd0, ovr}, {31'd0, m_ovr});
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic run_to(input int c);
    while (cyc < c) step();
  endtask

  initial begin
    int bc;
    // constant 512, decaying DC-free output, valid pulse timing
    en = 1; rdy = 1; audio = 10'd512;
    do_reset();
    chk("reset_sample", {16'd0, sample}, 0);
    chk("reset_valid", {31'd0, valid}, 0);
    chk("reset_overrun", {31'd0, ovr}, 0);
    for (int i = 0; i < 14; i++) begin
      step();
      if (cyc == 5) chk("valid_before_first", {31'd0, valid}, 0);
      if (cyc == 6) chk("valid_first", {31'd0, valid}, 1);
      if (cyc == 6) chk("first_sample", {16'd0, sample}, 16384);
      if (cyc == 7) chk("valid_pulse_end", {31'd0, valid}, 0);
      if (cyc == 10) chk("second_sample", {16'd0, sample}, 12288);
      if (cyc == 14) chk("third_sample", {16'd0, sample}, 9216);
    end
    // window alignment with a 0,4,8,12 ramp
    do_reset();
    while (cyc < 6) begin
      audio = 10'((cyc % 4) * 4);
      step();
    end
    chk("ramp_first", {16'd0, sample}, 192);
    // backpressure: overwrite and sticky overrun
    audio = 10'd512; rdy = 0;
    do_reset();
    run_to(9);
    chk("ovr_before_second", {31'd0, ovr}, 0);
    step();
    chk("ovr_at_second", {31'd0, ovr}, 1);
    run_to(14);
    chk("ovr_third_sample", {16'd0, sample}, 9216);
    chk("ovr_still_set", {31'd0, ovr}, 1);
    rdy = 1;
    step();
    rdy = 0;
    chk("valid_after_pulse", {31'd0, valid}, 0);
    step();
    chk("ovr_sticky", {31'd0, ovr}, 1);
    // ready in the same cycle as a load
    do_reset();
    run_to(9);
    rdy = 1;
    step();
    chk("coinc_valid", {31'd0, valid}, 1);
    chk("coinc_sample", {16'd0, sample}, 12288);
    chk("coinc_overrun", {31'd0, ovr}, 0);
    step();
    chk("coinc_consumed", {31'd0, valid}, 0);
    // reset with a sample in flight
    rdy = 0;
    do_reset();
    run_to(9);
    rst = 1;
    step();
    rst = 0;
    chk("midrst_sample", {16'd0, sample}, 0);
    chk("midrst_valid", {31'd0, valid}, 0);
    chk("midrst_overrun", {31'd0, ovr}, 0);
    audio = 10'd100; rdy = 1;
    run_to(5);
    chk("midrst_no_partial", {31'd0, valid}, 0);
    step();
    chk("midrst_first", {16'd0, sample}, 3200);
    // enable low at one S3 edge
    audio = 10'd512;
    do_reset();
    run_to(9);
    en = 0;
    step();
    en = 1;
    chk("disabled_sample", {16'd0, sample}, 0);
    chk("disabled_valid", {31'd0, valid}, 1);
    run_to(14);
    chk("reenabled_sample", {16'd0, sample}, 16384);
    // random traffic with occasional resets
    do_reset();
    for (int i = 0; i < 600; i++) begin
      audio = 10'($urandom_range(0, 1023));
      rdy = 1'($urandom_range(0, 1));
      en = ($urandom_range(0, 7) != 0);
      rst = ($urandom_range(0, 150) == 0);
      step();
    end
    rst = 0; en = 1; rdy = 1;
    // default parameters, full-scale input
    rst_b = 0;
    bc = 0;
    while (!valid_b && bc < 1300) begin
      step();
      bc++;
    end
    chk("b_timeout", {31'd0, valid_b}, 1);
    chk("b_latency", bc, 1127);
    chk("b_fullscale", {16'd0, sample_b}, 32736);
    chk("b_overrun", {31'd0, ovr_b}, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
